// File: rtl/sar_conv_scheduler.sv
// Sequences an 8-bit SAR ADC over multiplexed channels: select, settle, oversample,
// average, then stream one tagged result per channel over valid/ready.
module sar_conv_scheduler #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned CH_W     = 2,
    parameter int unsigned SETTLE   = 4,
    parameter int unsigned OSR_LOG2 = 2,
    parameter int unsigned TIMEOUT  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            continuous,
    input  logic [NCH-1:0]  ch_mask,
    output logic [CH_W-1:0] mux_sel,
    output logic            sar_start,
    input  logic            sar_done,
    input  logic [7:0]      sar_result,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [7:0]      res_data,
    output logic [CH_W-1:0] res_ch,
    output logic            busy,
    output logic            timeout_err
);
    localparam int unsigned ACC_W = 8 + OSR_LOG2;
    localparam int unsigned CNT_W = OSR_LOG2 + 1;
    localparam int unsigned SET_W = $clog2(SETTLE) + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT) + 1;
    localparam int unsigned NAVG  = 1 << OSR_LOG2;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StStart,
        StWait,
        StOutput,
        StNext
    } state_e;

    state_e           state_q, state_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic [CH_W-1:0]  ptr_q, ptr_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [CH_W-1:0]  first_q, first_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;
    logic             err_q, err_d;

    logic [ACC_W-1:0] acc_sum;
    logic [CH_W-1:0]  nxt_ch;
    logic             pass_done;

    // First set bit of m at or after index 'from', wrapping past NCH-1.
    function automatic logic [CH_W-1:0] find_set(input logic [NCH-1:0] m,
                                                 input int unsigned from);
        logic [CH_W-1:0] r;
        logic            hit;
        int unsigned     idx;
        r   = '0;
        hit = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = (from + i) % NCH;
            if (!hit && (|(m & (NCH'(1) << idx)))) begin
                r   = CH_W'(idx);
                hit = 1'b1;
            end
        end
        return r;
    endfunction

    // Distance of channel c ahead of the pass's first channel f, modulo NCH.
    function automatic int unsigned rel_pos(input logic [CH_W-1:0] c,
                                            input logic [CH_W-1:0] f);
        return (32'(c) + NCH - 32'(f)) % NCH;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            mask_q   <= '0;
            ptr_q    <= '0;
            ch_q     <= '0;
            first_q  <= '0;
            settle_q <= '0;
            tmo_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            ptr_q    <= ptr_d;
            ch_q     <= ch_d;
            first_q  <= first_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        ptr_d     = ptr_q;
        ch_d      = ch_q;
        first_d   = first_q;
        settle_d  = settle_q;
        tmo_d     = tmo_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        err_d     = err_q;
        acc_sum   = acc_q + ACC_W'(sar_result);
        nxt_ch    = find_set(mask_q, 32'(ch_q) + 32'd1);
        // Wrapping back to or past the first channel ends the pass.
        pass_done = rel_pos(nxt_ch, first_q) <= rel_pos(ch_q, first_q);

        unique case (state_q)
            StIdle: begin
                if (en && (ch_mask != '0)) begin
                    mask_d   = ch_mask;
                    err_d    = 1'b0;
                    ch_d     = find_set(ch_mask, 32'(ptr_q));
                    first_d  = ch_d;
                    settle_d = '0;
                    state_d  = StSelect;
                end
            end
            StSelect: begin
                if (settle_q == SET_W'(SETTLE - 1)) begin
                    state_d = StStart;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            StStart: begin
                tmo_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // A done arriving on the last allowed cycle still counts.
                if (sar_done) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NAVG - 1)) begin
                        data_d  = 8'(acc_sum >> OSR_LOG2);
                        state_d = StOutput;
                    end else begin
                        state_d = StStart;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StNext;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            StOutput: begin
                if (res_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StNext;
                end
            end
            StNext: begin
                ptr_d = nxt_ch;
                if (!en) begin
                    state_d = StIdle;
                end else if (!pass_done) begin
                    ch_d     = nxt_ch;
                    settle_d = '0;
                    state_d  = StSelect;
                end else if (continuous) begin
                    mask_d = ch_mask;
                    if (ch_mask != '0) begin
                        ch_d     = find_set(ch_mask, 32'(nxt_ch));
                        first_d  = ch_d;
                        settle_d = '0;
                        state_d  = StSelect;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign mux_sel     = ch_q;
    assign res_ch      = ch_q;
    assign res_data    = data_q;
    assign sar_start   = (state_q == StStart);
    assign res_valid   = (state_q == StOutput);
    assign busy        = (state_q != StIdle);
    assign timeout_err = err_q;

endmodule

// File: tb/tb_sar_conv_scheduler.sv
// Directed bench: one instance without averaging, one averaging four conversions,
// each driven by a fixed-latency SAR model.
module tb_sar_conv_scheduler;
    localparam int unsigned NCH     = 4;
    localparam int unsigned CH_W    = 2;
    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 32;
    localparam int          M_LAT   = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, continuous, res_ready, en0, en2;
    logic [NCH-1:0] ch_mask;

    logic [CH_W-1:0] mux0, rch0, mux2, rch2;
    logic            start0, done0, rv0, busy0, terr0;
    logic            start2, done2, rv2, busy2, terr2;
    logic [7:0]      res0, rdata0, res2, rdata2;

    sar_conv_scheduler #(
        .NCH(NCH), .CH_W(CH_W), .SETTLE(SETTLE), .OSR_LOG2(0), .TIMEOUT(TIMEOUT)
    ) u0 (
        .clk(clk), .rst(rst), .en(en0), .continuous(continuous), .ch_mask(ch_mask),
        .mux_sel(mux0), .sar_start(start0), .sar_done(done0), .sar_result(res0),
        .res_valid(rv0), .res_ready(res_ready), .res_data(rdata0), .res_ch(rch0),
        .busy(busy0), .timeout_err(terr0)
    );

    sar_conv_scheduler #(
        .NCH(NCH), .CH_W(CH_W), .SETTLE(SETTLE), .OSR_LOG2(2), .TIMEOUT(TIMEOUT)
    ) u2 (
        .clk(clk), .rst(rst), .en(en2), .continuous(continuous), .ch_mask(ch_mask),
        .mux_sel(mux2), .sar_start(start2), .sar_done(done2), .sar_result(res2),
        .res_valid(rv2), .res_ready(res_ready), .res_data(rdata2), .res_ch(rch2),
        .busy(busy2), .timeout_err(terr2)
    );

    // SAR model behaviour, shared by both models.
    logic [7:0] m_val;
    logic       m_ramp, m_skip0;
    int         pend0, cnt0, k0, pend2, cnt2, k2;

    initial begin
        done0 = 1'b0; res0 = '0; pend0 = 0; cnt0 = 0; k0 = 0;
        forever begin
            @(negedge clk);
            done0 = 1'b0;
            if (pend0 != 0) begin
                if (cnt0 == 0) begin
                    done0 = 1'b1;
                    res0  = m_ramp ? 8'(10 + (k0 % 4)) : m_val;
                    k0++;
                    pend0 = 0;
                end else cnt0--;
            end
            if (start0 && !(m_skip0 && mux0 == '0)) begin pend0 = 1; cnt0 = M_LAT - 1; end
        end
    end

    initial begin
        done2 = 1'b0; res2 = '0; pend2 = 0; cnt2 = 0; k2 = 0;
        forever begin
            @(negedge clk);
            done2 = 1'b0;
            if (pend2 != 0) begin
                if (cnt2 == 0) begin
                    done2 = 1'b1;
                    res2  = m_ramp ? 8'(10 + (k2 % 4)) : m_val;
                    k2++;
                    pend2 = 0;
                end else cnt2--;
            end
            if (start2 && !(m_skip0 && mux2 == '0)) begin pend2 = 1; cnt2 = M_LAT - 1; end
        end
    end

    // Transfer and start monitor, sampled well clear of both clock edges.
    logic [7:0]      q_data0[$], q_data2[$];
    logic [CH_W-1:0] q_ch0[$], q_ch2[$];
    int              n_start2 = 0;

    initial forever begin
        @(negedge clk);
        #3;
        if (start2) n_start2++;
        if (rv0 && res_ready) begin q_data0.push_back(rdata0); q_ch0.push_back(rch0); end
        if (rv2 && res_ready) begin q_data2.push_back(rdata2); q_ch2.push_back(rch2); end
    end

    int n_pass = 0, n_total = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int              n, bad, s;
    logic [CH_W-1:0] exp_ch [4] = '{2'd0, 2'd3, 2'd0, 2'd3};

    initial begin
        rst = 1'b1; en0 = 1'b0; en2 = 1'b0; continuous = 1'b0; ch_mask = '0;
        res_ready = 1'b1; m_val = '0; m_ramp = 1'b0; m_skip0 = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(busy2), 0);
        check("rst_valid", 32'(rv2), 0);
        check("rst_start", 32'(start2), 0);
        check("rst_mux", 32'(mux2), 0);
        check("rst_data", 32'(rdata2), 0);
        check("rst_err", 32'(terr2), 0);
        check("rst_busy0", 32'(busy0), 0);
        rst = 1'b0;

        // Single channel, no averaging, with start latency.
        ch_mask = 4'b0001; m_val = 8'hA5; en0 = 1'b1;
        tick();
        check("t1_busy", 32'(busy0), 1);
        check("t1_no_start", 32'(start0), 0);
        en0 = 1'b0;
        bad = 0;
        for (int i = 1; i < int'(SETTLE); i++) begin tick(); if (start0) bad++; end
        check("t1_settle_quiet", 32'(bad), 0);
        tick();
        check("t1_start_lat", 32'(start0), 1);
        n = 0;
        while (!done0 && n < 40) begin tick(); n++; end
        check("t1_done_seen", 32'(done0), 1);
        tick();
        check("t1_valid_lat", 32'(rv0), 1);
        check("t1_data", 32'(rdata0), 32'h a5);
        check("t1_ch", 32'(rch0), 0);
        tick();
        check("t1_valid_drop", 32'(rv0), 0);
        tick();
        check("t1_idle", 32'(busy0), 0);
        check("t1_nxfer", 32'(q_data0.size()), 1);

        // Two channels, four-sample average, single pass.
        ch_mask = 4'b1010; m_ramp = 1'b1; k2 = 0; n_start2 = 0; en2 = 1'b1;
        q_data2.delete(); q_ch2.delete();
        n = 0;
        while (q_data2.size() < 2 && n < 300) begin tick(); n++; end
        check("t2_nxfer", 32'(q_data2.size()), 2);
        check("t2_ch_a", 32'(q_ch2[0]), 1);
        check("t2_data_a", 32'(q_data2[0]), 11);
        check("t2_ch_b", 32'(q_ch2[1]), 3);
        check("t2_data_b", 32'(q_data2[1]), 11);
        n = 0;
        while (busy2 && n < 20) begin tick(); n++; end
        check("t2_idle", 32'(busy2), 0);
        en2 = 1'b0;
        tick();
        check("t2_nstart", 32'(n_start2), 8);

        // Back-pressure holds the result and stalls scheduling.
        ch_mask = 4'b0100; m_ramp = 1'b0; m_val = 8'h37; res_ready = 1'b0; en2 = 1'b1;
        q_data2.delete(); q_ch2.delete();
        n = 0;
        while (!rv2 && n < 100) begin tick(); n++; end
        check("t3_valid", 32'(rv2), 1);
        s = n_start2;
        bad = 0;
        repeat (20) begin
            tick();
            if (!rv2 || rdata2 !== 8'h37 || rch2 !== 2'd2 || start2) bad++;
        end
        check("t3_hold", 32'(bad), 0);
        check("t3_data", 32'(rdata2), 32'h37);
        check("t3_ch", 32'(rch2), 2);
        res_ready = 1'b1;
        tick();
        check("t3_drop", 32'(rv2), 0);
        check("t3_nxfer", 32'(q_data2.size()), 1);
        check("t3_nostart", 32'(n_start2), 32'(s));
        n = 0;
        while (busy2 && n < 20) begin tick(); n++; end
        en2 = 1'b0;

        // Channel 0 never completes: timeout, then channel 1 still delivered.
        ch_mask = 4'b0011; m_val = 8'h40; m_skip0 = 1'b1; en2 = 1'b1;
        q_data2.delete(); q_ch2.delete();
        n = 0;
        while (!start2 && n < 20) begin tick(); n++; end
        check("t4_start", 32'(start2), 1);
        check("t4_first_ch", 32'(mux2), 0);
        repeat (TIMEOUT) tick();
        check("t4_err_early", 32'(terr2), 0);
        tick();
        check("t4_err_set", 32'(terr2), 1);
        n = 0;
        while (q_data2.size() < 1 && n < 150) begin tick(); n++; end
        check("t4_ch", 32'(q_ch2[0]), 1);
        check("t4_data", 32'(q_data2[0]), 32'h40);
        n = 0;
        while (busy2 && n < 20) begin tick(); n++; end
        en2 = 1'b0;
        tick();
        check("t4_nxfer", 32'(q_data2.size()), 1);
        check("t4_sticky", 32'(terr2), 1);
        m_skip0 = 1'b0;

        // Reset during WAIT; the late done must be ignored.
        ch_mask = 4'b0001; m_val = 8'h55; en2 = 1'b1;
        q_data2.delete(); q_ch2.delete();
        n = 0;
        while (!start2 && n < 20) begin tick(); n++; end
        en2 = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("t5_busy", 32'(busy2), 0);
        check("t5_valid", 32'(rv2), 0);
        check("t5_mux", 32'(mux2), 0);
        check("t5_data", 32'(rdata2), 0);
        check("t5_ch", 32'(rch2), 0);
        rst = 1'b0;
        bad = 0;
        repeat (15) begin tick(); if (busy2 || rv2 || start2) bad++; end
        check("t5_ignore_done", 32'(bad), 0);
        check("t5_nxfer", 32'(q_data2.size()), 0);

        // Continuous passes over channels 0 and 3.
        ch_mask = 4'b1001; m_val = 8'hFF; continuous = 1'b1; en2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!(busy2 && mux2 == exp_ch[i]) && n < 80) begin tick(); n++; end
            check("t6_select", 32'(mux2), 32'(exp_ch[i]));
            n = 0;
            while (!start2 && n < 20) begin tick(); n++; end
            check("t6_settle", 32'(n), SETTLE);
            n = 0;
            while (!rv2 && n < 80) begin tick(); n++; end
            check("t6_ch", 32'(rch2), 32'(exp_ch[i]));
            check("t6_data", 32'(rdata2), 32'hff);
        end
        ch_mask = '0;
        repeat (2) tick();
        check("t6_relatch_idle", 32'(busy2), 0);
        tick();
        check("t6_stay_idle", 32'(busy2), 0);
        en2 = 1'b0; continuous = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
